// File: rtl/pol_sweep_pkg.sv
// Shared types and constants for the polMEM sweep sequencer.
// The optional abort input is enabled by defining POL_SWEEP_ABORT_EN.
package pol_sweep_pkg;

  // Default widths: polMEM address, sign-magnitude result, running-sum accumulator
  localparam int DEF_AW = 4;
  localparam int DEF_DW = 9;
  localparam int DEF_SW = 13;

  // Sequencer states; each address costs WRITE + READ + at least one EMIT cycle
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    EMIT,
    DONE
  } state_t;

  // polMEM argument codes
  localparam logic [1:0] ARG_P1 = 2'b00;
  localparam logic [1:0] ARG_P2 = 2'b01;
  localparam logic [1:0] ARG_M1 = 2'b10;
  localparam logic [1:0] ARG_M2 = 2'b11;

  // polMEM operation codes
  localparam logic OP_POL = 1'b0;
  localparam logic OP_DER = 1'b1;

endpackage

// File: rtl/pol_sweep_ctrl_if.sv
// Bundle of command, status, polMEM and result-stream signals of the sweep sequencer.
// master = the sequencer itself, slave = the host / polMEM side.
// The optional abort input (POL_SWEEP_ABORT_EN) stays a plain port on the sequencer.
interface pol_sweep_ctrl_if
  import pol_sweep_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int SW = DEF_SW
);

  logic                 start;
  logic                 op_in;
  logic [1:0]           arg_in;
  logic [AW-1:0]        first_addr;
  logic [AW-1:0]        last_addr;
  logic                 busy;
  logic                 done;
  logic                 mem_mode;
  logic [AW-1:0]        mem_addr;
  logic                 mem_op;
  logic [1:0]           mem_arg;
  logic [DW-1:0]        mem_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [DW-1:0]        res_data;
  logic [AW-1:0]        res_addr;
  logic signed [SW-1:0] acc_sum;

  modport master (
    input  start, op_in, arg_in, first_addr, last_addr, mem_data, res_ready,
    output busy, done, mem_mode, mem_addr, mem_op, mem_arg,
           res_valid, res_data, res_addr, acc_sum
  );

  modport slave (
    output start, op_in, arg_in, first_addr, last_addr, mem_data, res_ready,
    input  busy, done, mem_mode, mem_addr, mem_op, mem_arg,
           res_valid, res_data, res_addr, acc_sum
  );

endinterface

// File: rtl/pol_sweep_ctrl_sm_to_tc.sv
// Sign-magnitude (DW bits, sign in the MSB) to two's-complement (SW bits) converter.
// Negative zero maps to 0 because negating a zero magnitude yields zero.
module sm_to_tc #(
  parameter int DW = 9,
  parameter int SW = 13
) (
  input  logic [DW-1:0]        sm,
  output logic signed [SW-1:0] tc
);

  logic [SW-1:0] mag;

  // Zero-extend the magnitude, then negate it when the sign bit is set
  assign mag = {{(SW-DW+1){1'b0}}, sm[DW-2:0]};
  assign tc  = sm[DW-1] ? $signed(-mag) : $signed(mag);

endmodule

// File: rtl/pol_sweep_ctrl.sv
// polMEM sweep sequencer: for each address of a (possibly wrapping) range it issues a
// write cycle, a read cycle, then offers the stored result on a valid/ready stream while
// accumulating a signed running sum. Define POL_SWEEP_ABORT_EN to add the abort input.
module pol_sweep_ctrl
  import pol_sweep_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int SW = DEF_SW
) (
  input logic CLK,
  input logic RST,
`ifdef POL_SWEEP_ABORT_EN
  input logic abort,
`endif
  pol_sweep_ctrl_if.master bus
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t               state;
  logic [AW-1:0]        cur;
  logic [AW:0]          cnt;
  logic                 busy_q;
  logic                 done_q;
  logic                 mode_q;
  logic                 op_q;
  logic [1:0]           arg_q;
  logic                 res_valid_q;
  logic [DW-1:0]        res_data_q;
  logic [AW-1:0]        res_addr_q;
  logic signed [SW-1:0] acc_q;
  logic signed [SW-1:0] tc_val;
  logic                 abort_req;

  // Abort request, tied off when the feature is not built in
`ifdef POL_SWEEP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Signed value of the word currently read back from polMEM
  sm_to_tc #(.DW(DW), .SW(SW)) u_sm_to_tc (
    .sm (bus.mem_data),
    .tc (tc_val)
  );

  // Sweep sequencer: state, address/count bookkeeping and all registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cur         <= '0;
      cnt         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= 1'b0;
      op_q        <= 1'b0;
      arg_q       <= 2'b00;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_addr_q  <= '0;
      acc_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= WRITE;
            busy_q <= 1'b1;
            acc_q  <= '0;
            cur    <= bus.first_addr;
            cnt    <= {1'b0, bus.last_addr - bus.first_addr} + CNT_ONE;
            op_q   <= bus.op_in;
            arg_q  <= bus.arg_in;
            mode_q <= 1'b1;
          end
        end
        WRITE: begin
          mode_q <= 1'b0;
          if (abort_req) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          if (abort_req) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            res_data_q  <= bus.mem_data;
            res_addr_q  <= cur;
            res_valid_q <= 1'b1;
            acc_q       <= acc_q + tc_val;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (abort_req) begin
            res_valid_q <= 1'b0;
            state       <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            cnt         <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              cur    <= cur + ADDR_ONE;
              mode_q <= 1'b1;
              state  <= WRITE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // An abort in WRITE must suppress the write edge, so the mode is gated combinationally
  assign bus.mem_mode  = mode_q & ~abort_req;
  assign bus.mem_addr  = cur;
  assign bus.mem_op    = op_q;
  assign bus.mem_arg   = arg_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_addr  = res_addr_q;
  assign bus.acc_sum   = acc_q;

endmodule

// File: tb/tb_pol_sweep_ctrl.sv
// Self-checking bench for pol_sweep_ctrl with a small behavioural polMEM.
// Define POL_SWEEP_ABORT_EN to also exercise the abort input.
module tb_pol_sweep_ctrl;
  import pol_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [8:0] pmem [16];
  logic [8:0] obs_data [16];
  logic [3:0] obs_addr [16];
  int         obs_cnt;
  int         obs_done;
  logic       obs_busy_at_done;

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  pol_sweep_ctrl_if bus_if ();

`ifdef POL_SWEEP_ABORT_EN
  logic abort;
`endif

  pol_sweep_ctrl dut (
    .CLK   (clk),
    .RST   (rst),
`ifdef POL_SWEEP_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus_if.master)
  );

  // polMEM result table for the directed cases; other points use an address-derived pattern
  function automatic logic [8:0] eval(input logic op, input logic [1:0] arg, input logic [3:0] a);
    logic [8:0] v;
    v = {a[0], 1'b0, op, arg, a};
    case ({op, arg, a})
      {OP_POL, ARG_P1, 4'd0}:  v = 9'h005;
      {OP_POL, ARG_P1, 4'd1}:  v = 9'h003;
      {OP_POL, ARG_P1, 4'd2}:  v = 9'h001;
      {OP_POL, ARG_P1, 4'd3}:  v = 9'h101;
      {OP_POL, ARG_P1, 4'd14}: v = 9'h101;
      {OP_POL, ARG_P1, 4'd15}: v = 9'h101;
      {OP_DER, ARG_M2, 4'd8}:  v = 9'h019;
      {OP_DER, ARG_M2, 4'd9}:  v = 9'h017;
      {OP_DER, ARG_M2, 4'd10}: v = 9'h017;
      {OP_DER, ARG_M2, 4'd11}: v = 9'h029;
      {OP_DER, ARG_M1, 4'd4}:  v = 9'h10A;
      {OP_DER, ARG_M1, 4'd5}:  v = 9'h104;
      {OP_DER, ARG_M1, 4'd6}:  v = 9'h104;
      {OP_DER, ARG_M1, 4'd7}:  v = 9'h106;
      {OP_POL, ARG_P2, 4'd0}:  v = 9'h100;
      default: ;
    endcase
    return v;
  endfunction

  // polMEM model: evaluate-and-store on a write edge, asynchronous read
  always @(posedge clk) begin
    if (bus_if.mem_mode === 1'b1)
      pmem[bus_if.mem_addr] <= eval(bus_if.mem_op, bus_if.mem_arg, bus_if.mem_addr);
  end
  assign bus_if.mem_data = pmem[bus_if.mem_addr];

  // Pulse start for one cycle; returns at the falling edge of the first WRITE cycle
  task automatic start_sweep(input logic op, input logic [1:0] arg,
                             input logic [3:0] first, input logic [3:0] last);
    @(negedge clk);
    bus_if.start      = 1'b1;
    bus_if.op_in      = op;
    bus_if.arg_in     = arg;
    bus_if.first_addr = first;
    bus_if.last_addr  = last;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  // Run a sweep with res_ready high, logging every result and the cycle done appears
  task automatic run_sweep(input logic op, input logic [1:0] arg,
                           input logic [3:0] first, input logic [3:0] last);
    obs_cnt  = 0;
    obs_done = -1;
    obs_busy_at_done = 1'bx;
    bus_if.res_ready = 1'b1;
    start_sweep(op, arg, first, last);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (bus_if.res_valid === 1'b1 && obs_cnt < 16) begin
        obs_data[obs_cnt] = bus_if.res_data;
        obs_addr[obs_cnt] = bus_if.res_addr;
        obs_cnt++;
      end
      if (bus_if.done === 1'b1) begin
        obs_done = cyc;
        obs_busy_at_done = bus_if.busy;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus_if.busy, bus_if.done, bus_if.mem_mode, bus_if.mem_addr, bus_if.mem_op,
         bus_if.mem_arg, bus_if.res_valid, bus_if.res_data, bus_if.res_addr,
         bus_if.acc_sum} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b mode=%b addr=%h res_valid=%b res_data=%h acc=%h, required all zero",
               bus_if.busy, bus_if.done, bus_if.mem_mode, bus_if.mem_addr,
               bus_if.res_valid, bus_if.res_data, bus_if.acc_sum);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [8:0] exp_d [4] = '{9'h005, 9'h003, 9'h001, 9'h101};
    logic [3:0] exp_a [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    run_sweep(OP_POL, ARG_P1, 4'd0, 4'd3);
    n_checks++;
    if (obs_cnt !== 4) begin
      n_fail++; $display("[TB] FAIL basic_count: got %0d, required 4", obs_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_a[i] || obs_data[i] !== exp_d[i]) begin
        n_fail++;
        $display("[TB] FAIL basic_result%0d: got %0d:%b, required %0d:%b",
                 i, obs_addr[i], obs_data[i], exp_a[i], exp_d[i]);
      end
    end
    n_checks++;
    if (bus_if.acc_sum !== 13'sd8) begin
      n_fail++; $display("[TB] FAIL basic_acc: got %0d, required 8", bus_if.acc_sum);
    end
    n_checks++;
    if (obs_done !== 13) begin
      n_fail++; $display("[TB] FAIL basic_done_cycle: got %0d, required 13", obs_done);
    end
    n_checks++;
    if (obs_busy_at_done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL basic_busy_at_done: got %b, required 0", obs_busy_at_done);
    end
  endtask

  task automatic test_derivative();
    logic [8:0] exp_d [4] = '{9'h019, 9'h017, 9'h017, 9'h029};
    run_sweep(OP_DER, ARG_M2, 4'd8, 4'd11);
    n_checks++;
    if (obs_cnt !== 4) begin
      n_fail++; $display("[TB] FAIL deriv_count: got %0d, required 4", obs_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_addr[i] !== 4'(8 + i) || obs_data[i] !== exp_d[i]) begin
        n_fail++;
        $display("[TB] FAIL deriv_result%0d: got %0d:%b, required %0d:%b",
                 i, obs_addr[i], obs_data[i], 8 + i, exp_d[i]);
      end
    end
    n_checks++;
    if (bus_if.acc_sum !== 13'sd112) begin
      n_fail++; $display("[TB] FAIL deriv_acc: got %0d, required 112", bus_if.acc_sum);
    end
  endtask

  task automatic test_negative_sum();
    logic [8:0] exp_d [4] = '{9'h10A, 9'h104, 9'h104, 9'h106};
    run_sweep(OP_DER, ARG_M1, 4'd4, 4'd7);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_addr[i] !== 4'(4 + i) || obs_data[i] !== exp_d[i]) begin
        n_fail++;
        $display("[TB] FAIL neg_result%0d: got %0d:%b, required %0d:%b",
                 i, obs_addr[i], obs_data[i], 4 + i, exp_d[i]);
      end
    end
    n_checks++;
    if (bus_if.acc_sum !== 13'b1111111101000) begin
      n_fail++; $display("[TB] FAIL neg_acc: got %b, required 1111111101000", bus_if.acc_sum);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] exp_d [4] = '{9'h101, 9'h101, 9'h005, 9'h003};
    logic [3:0] exp_a [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    run_sweep(OP_POL, ARG_P1, 4'd14, 4'd1);
    n_checks++;
    if (obs_cnt !== 4) begin
      n_fail++; $display("[TB] FAIL wrap_count: got %0d, required 4", obs_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_a[i] || obs_data[i] !== exp_d[i]) begin
        n_fail++;
        $display("[TB] FAIL wrap_result%0d: got %0d:%b, required %0d:%b",
                 i, obs_addr[i], obs_data[i], exp_a[i], exp_d[i]);
      end
    end
    n_checks++;
    if (bus_if.acc_sum !== 13'sd6) begin
      n_fail++; $display("[TB] FAIL wrap_acc: got %0d, required 6", bus_if.acc_sum);
    end
  endtask

  task automatic test_single();
    run_sweep(OP_POL, ARG_P2, 4'd5, 4'd5);
    n_checks++;
    if (obs_cnt !== 1 || obs_addr[0] !== 4'd5 || obs_data[0] !== 9'h115) begin
      n_fail++;
      $display("[TB] FAIL single_result: got count %0d %0d:%b, required count 1 5:100010101",
               obs_cnt, obs_addr[0], obs_data[0]);
    end
    n_checks++;
    if (obs_done !== 4) begin
      n_fail++; $display("[TB] FAIL single_done_cycle: got %0d, required 4", obs_done);
    end
    n_checks++;
    if (bus_if.acc_sum !== -13'sd21) begin
      n_fail++; $display("[TB] FAIL single_acc: got %0d, required -21", bus_if.acc_sum);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] held_d;
    logic [3:0] held_a;
    logic       seen2;
    logic       done_seen;
    bus_if.res_ready = 1'b0;
    start_sweep(OP_POL, ARG_P2, 4'd0, 4'd1);
    for (int i = 0; i < 20 && bus_if.res_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (bus_if.res_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL bp_first_valid: got %b, required 1", bus_if.res_valid);
    end
    held_d = bus_if.res_data;
    held_a = bus_if.res_addr;
    n_checks++;
    if (held_d !== 9'h100 || held_a !== 4'd0 || bus_if.acc_sum !== 13'sd0) begin
      n_fail++;
      $display("[TB] FAIL bp_negzero: got %0d:%b acc %0d, required 0:100000000 acc 0",
               held_a, held_d, bus_if.acc_sum);
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        bus_if.start      = 1'b1;
        bus_if.op_in      = OP_DER;
        bus_if.first_addr = 4'd9;
      end
      if (k == 2) bus_if.start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== held_d ||
          bus_if.res_addr !== held_a || bus_if.mem_mode !== 1'b0 || bus_if.busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b %0d:%b mode=%b busy=%b, required valid=1 %0d:%b mode=0 busy=1",
                 k, bus_if.res_valid, bus_if.res_addr, bus_if.res_data,
                 bus_if.mem_mode, bus_if.busy, held_a, held_d);
      end
    end
    bus_if.res_ready = 1'b1;
    seen2 = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      @(negedge clk);
      if (bus_if.res_valid === 1'b1) begin
        seen2 = 1'b1;
        n_checks++;
        if (bus_if.res_addr !== 4'd1 || bus_if.res_data !== 9'h111 || bus_if.mem_op !== OP_POL) begin
          n_fail++;
          $display("[TB] FAIL bp_second: got %0d:%b op=%b, required 1:100010001 op=0",
                   bus_if.res_addr, bus_if.res_data, bus_if.mem_op);
        end
      end
      if (bus_if.done === 1'b1) done_seen = 1'b1;
    end
    n_checks++;
    if (!(seen2 && done_seen)) begin
      n_fail++; $display("[TB] FAIL bp_completion: got result=%b done=%b, required 1 1", seen2, done_seen);
    end
    n_checks++;
    if (bus_if.acc_sum !== -13'sd17) begin
      n_fail++; $display("[TB] FAIL bp_acc: got %0d, required -17", bus_if.acc_sum);
    end
  endtask

  task automatic test_reset_mid();
    logic done_seen;
    bus_if.res_ready = 1'b1;
    start_sweep(OP_POL, ARG_P1, 4'd0, 4'd3);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus_if.mem_mode !== 1'b0 || bus_if.mem_addr !== 4'd1 || bus_if.busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_in_read: got mode=%b addr=%0d busy=%b, required mode=0 addr=1 busy=1",
               bus_if.mem_mode, bus_if.mem_addr, bus_if.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus_if.busy, bus_if.done, bus_if.mem_mode, bus_if.mem_addr, bus_if.mem_op,
         bus_if.mem_arg, bus_if.res_valid, bus_if.res_data, bus_if.res_addr,
         bus_if.acc_sum} !== '0) begin
      n_fail++;
      $display("[TB] FAIL rstmid_outputs: busy=%b done=%b mode=%b addr=%h res_valid=%b res_data=%h acc=%h, required all zero",
               bus_if.busy, bus_if.done, bus_if.mem_mode, bus_if.mem_addr,
               bus_if.res_valid, bus_if.res_data, bus_if.acc_sum);
    end
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) done_seen = 1'b1;
    end
    n_checks++;
    if (done_seen !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rstmid_no_done: got activity=%b, required 0", done_seen);
    end
  endtask

`ifdef POL_SWEEP_ABORT_EN
  task automatic test_abort();
    bus_if.res_ready = 1'b0;
    start_sweep(OP_DER, ARG_M2, 4'd8, 4'd11);
    for (int i = 0; i < 20 && bus_if.res_valid !== 1'b1; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (bus_if.done !== 1'b1 || bus_if.res_valid !== 1'b0 || bus_if.busy !== 1'b0 ||
        bus_if.acc_sum !== 13'sd25) begin
      n_fail++;
      $display("[TB] FAIL abort_emit: got done=%b valid=%b busy=%b acc=%0d, required 1 0 0 25",
               bus_if.done, bus_if.res_valid, bus_if.busy, bus_if.acc_sum);
    end
    bus_if.res_ready = 1'b1;
    start_sweep(OP_POL, ARG_P1, 4'd2, 4'd3);
    abort = 1'b1;
    #1;
    n_checks++;
    if (bus_if.mem_mode !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_write_mode: got %b, required 0", bus_if.mem_mode);
    end
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (bus_if.done !== 1'b1 || bus_if.acc_sum !== 13'sd0) begin
      n_fail++;
      $display("[TB] FAIL abort_write_done: got done=%b acc=%0d, required 1 0",
               bus_if.done, bus_if.acc_sum);
    end
  endtask
`endif

  // Test sequence
  initial begin
    for (int i = 0; i < 16; i++) pmem[i] = 9'h000;
    rst                = 1'b1;
    bus_if.start       = 1'b0;
    bus_if.op_in       = OP_POL;
    bus_if.arg_in      = ARG_P1;
    bus_if.first_addr  = 4'd0;
    bus_if.last_addr   = 4'd0;
    bus_if.res_ready   = 1'b1;
`ifdef POL_SWEEP_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_derivative();
    test_negative_sum();
    test_wrap();
    test_single();
    test_backpressure();
    test_reset_mid();
`ifdef POL_SWEEP_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
